// File: rtl/imm_arith_encoder.sv
// imm_arith_encoder: turns an OP-IMM operation kind plus rd/rs1/imm fields
// into a 32-bit RV32I instruction word and buffers it in a DEPTH-entry FIFO.
// Illegal requests are stored as a canonical NOP with the error flag set.
// Optional feature macro: IMM_ENC_STATS_EN adds saturating accept counters
// (stat_enc for legal words, stat_err for illegal words).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and all payload fields stable until
// the transfer. in_ready depends only on registered FIFO occupancy, and
// out_valid depends only on registered occupancy, so there is no
// combinational path between the input and output sides.

package imm_arith_pkg;
  typedef enum logic [3:0] {
    iak_addi    = 4'd0,
    iak_slti    = 4'd1,
    iak_sltiu   = 4'd2,
    iak_xori    = 4'd3,
    iak_ori     = 4'd4,
    iak_andi    = 4'd5,
    iak_slli    = 4'd6,
    iak_srli    = 4'd7,
    iak_srai    = 4'd8,
    iak_invalid = 4'd15
  } imm_arith_kind_t;
endpackage

module imm_arith_encoder
  import imm_arith_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  imm_arith_kind_t in_kind,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [11:0]     in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_err
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_enc,
  output logic [CNT_W-1:0] stat_err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Encoder results for the current request.
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        legal;
  logic [31:0] enc_instr;

  // FIFO state. Each entry holds {err, instr}.
  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [32:0]      last_head;

  logic push;
  logic wr_en;
  logic pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  // A push coinciding with flush completes the handshake but is discarded.
  assign wr_en     = push && !flush;
  assign pop       = out_valid && out_ready;

  // Combinational OP-IMM encode: funct3/funct7 by kind, legality check.
  always_comb begin
    funct3    = 3'b000;
    funct7    = 7'b0000000;
    is_shift  = 1'b0;
    legal     = 1'b1;
    enc_instr = NOP_WORD;
    case (in_kind)
      iak_addi:  funct3 = 3'b000;
      iak_slti:  funct3 = 3'b010;
      iak_sltiu: funct3 = 3'b011;
      iak_xori:  funct3 = 3'b100;
      iak_ori:   funct3 = 3'b110;
      iak_andi:  funct3 = 3'b111;
      iak_slli: begin
        funct3   = 3'b001;
        is_shift = 1'b1;
      end
      iak_srli: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
      end
      iak_srai: begin
        funct3   = 3'b101;
        funct7   = 7'b0100000;
        is_shift = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
    // Shift amounts above 31 have no RV32I encoding.
    if (is_shift && (in_imm[11:5] != 7'b0)) begin
      legal = 1'b0;
    end
    if (!legal) begin
      enc_instr = NOP_WORD;
    end else if (is_shift) begin
      enc_instr = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_OP_IMM};
    end else begin
      enc_instr = {in_imm, in_rs1, funct3, in_rd, OPC_OP_IMM};
    end
  end

  // FIFO storage: written on accepted, non-flushed pushes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {!legal, enc_instr};
    end
  end

  // FIFO pointers and occupancy; flush clears them synchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Remember the last head shown so outputs hold while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_head <= '0;
    end else if (out_valid) begin
      last_head <= mem[rd_ptr];
    end
  end

  assign out_instr = out_valid ? mem[rd_ptr][31:0] : last_head[31:0];
  assign out_err   = out_valid ? mem[rd_ptr][32]   : last_head[32];

`ifdef IMM_ENC_STATS_EN
  // Saturating accept counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_enc <= '0;
      stat_err <= '0;
    end else if (push) begin
      if (legal) begin
        if (stat_enc != '1) stat_enc <= stat_enc + 1'b1;
      end else begin
        if (stat_err != '1) stat_err <= stat_err + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_arith_encoder.sv
// tb_imm_arith_encoder: directed bench for imm_arith_encoder. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling
// edge. Delivered words are checked against an expected queue filled with
// hand-computed instruction words as each request is accepted.
// Define IMM_ENC_STATS_EN to also check the statistics counters.

module tb_imm_arith_encoder;
  import imm_arith_pkg::*;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  imm_arith_kind_t in_kind;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [11:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;
`ifdef IMM_ENC_STATS_EN
  logic [15:0]     stat_enc;
  logic [15:0]     stat_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [32:0] exp_q[$];

  imm_arith_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
`ifdef IMM_ENC_STATS_EN
    ,
    .stat_enc  (stat_enc),
    .stat_err  (stat_err)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input imm_arith_kind_t k, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [11:0] imm);
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  // Present a request and hold it until accepted; record the expected word.
  task automatic send(input imm_arith_kind_t k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [11:0] imm,
                      input logic exp_err, input logic [31:0] exp_instr);
    logic rdy;
    bit   done;
    done = 0;
    set_req(k, rd, rs1, imm);
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({exp_err, exp_instr});
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 33'(done), 33'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  // ---------------- scoreboard: delivered words ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_miss++;
        $error("FAIL stale_word: got %h exp none", {out_err, out_instr});
      end
      if (exp_q.size() != 0) chk("out_word", {out_err, out_instr}, exp_q.pop_front());
    end
  end

  // ---------------- protocol: held request stays stable ----------------
  logic        pend;
  logic [25:0] prev_req;
  always @(posedge clk) begin
    if (pend && !rst) chk("in_stable", 33'({in_kind, in_rd, in_rs1, in_imm}), 33'(prev_req));
    pend     <= in_valid && !in_ready && !rst;
    prev_req <= {in_kind, in_rd, in_rs1, in_imm};
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = iak_addi; in_rd = '0; in_rs1 = '0; in_imm = '0;

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_instr", 33'(out_instr), 33'd0);
    chk("rst_out_err",   33'(out_err),   33'd0);
    chk("rst_in_ready",  33'(in_ready),  33'd1);
`ifdef IMM_ENC_STATS_EN
    chk("rst_stat_enc", 33'(stat_enc), 33'd0);
    chk("rst_stat_err", 33'(stat_err), 33'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // addi, one-cycle latency, then hold after the pop
    out_ready = 1'b1;
    send(iak_addi, 5'd1, 5'd2, 12'hFFF, 1'b0, 32'hFFF10093);
    @(negedge clk);
    chk("addi_valid", 33'(out_valid), 33'd1);
    chk("addi_instr", 33'(out_instr), 33'hFFF10093);
    chk("addi_err",   33'(out_err),   33'd0);
    @(negedge clk);
    chk("hold_valid", 33'(out_valid), 33'd0);
    chk("hold_instr", 33'(out_instr), 33'hFFF10093);

    // srai / srli with identical fields
    @(posedge clk); #1;
    send(iak_srai, 5'd5, 5'd6, 12'h003, 1'b0, 32'h40335293);
    send(iak_srli, 5'd5, 5'd6, 12'h003, 1'b0, 32'h00335293);
    drain();

    // Reset pulse, then illegal requests
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(iak_slli,    5'd1, 5'd1, 12'h020, 1'b1, 32'h00000013);
    send(iak_invalid, 5'd1, 5'd1, 12'h000, 1'b1, 32'h00000013);
    drain();
`ifdef IMM_ENC_STATS_EN
    chk("ill_stat_err", 33'(stat_err), 33'd2);
    chk("ill_stat_enc", 33'(stat_enc), 33'd0);
`endif

    // Further kinds and immediate boundaries
    @(posedge clk); #1;
    send(iak_xori,  5'd3,  5'd4,  12'h7FF, 1'b0, 32'h7FF24193);
    send(iak_andi,  5'd31, 5'd31, 12'h800, 1'b0, 32'h800FFF93);
    send(iak_ori,   5'd0,  5'd0,  12'h000, 1'b0, 32'h00006013);
    send(iak_slti,  5'd2,  5'd3,  12'h005, 1'b0, 32'h0051A113);
    send(iak_sltiu, 5'd7,  5'd8,  12'h001, 1'b0, 32'h00143393);
    send(iak_slli,  5'd1,  5'd1,  12'h01F, 1'b0, 32'h01F09093);
    send(iak_srai,  5'd5,  5'd6,  12'h41F, 1'b1, 32'h00000013);
    drain();

    // Backpressure: two accepted, third held until the first pop
    @(posedge clk); #1 out_ready = 1'b0;
    send(iak_slti,  5'd2, 5'd3, 12'h005, 1'b0, 32'h0051A113);
    send(iak_sltiu, 5'd7, 5'd8, 12'h001, 1'b0, 32'h00143393);
    set_req(iak_ori, 5'd0, 5'd0, 12'h000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_full_ready", 33'(in_ready), 33'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pre_pop_ready", 33'(in_ready), 33'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_post_pop_ready", 33'(in_ready), 33'd1);
    @(posedge clk);
    exp_q.push_back({1'b0, 32'h00006013});
    #1 in_valid = 1'b0;
    drain();

    // Simultaneous push and pop at count = 1
    @(posedge clk); #1 out_ready = 1'b0;
    send(iak_addi, 5'd0, 5'd0, 12'd0, 1'b0, 32'h00000013);
    out_ready = 1'b1;
    set_req(iak_addi, 5'd1, 5'd1, 12'd1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("pp_out_valid", 33'(out_valid), 33'd1);
      chk("pp_in_ready",  33'(in_ready),  33'd1);
      @(posedge clk);
      exp_q.push_back({1'b0, (32'(i) << 20) | (32'(i) << 15) | (32'(i) << 7) | 32'h13});
      #1;
      if (i < 10) set_req(iak_addi, 5'(i + 1), 5'(i + 1), 12'(i + 1));
      else in_valid = 1'b0;
    end
    drain();

    // Asynchronous reset with two entries queued
    @(posedge clk); #1 out_ready = 1'b0;
    send(iak_xori, 5'd3, 5'd4, 12'h7FF, 1'b0, 32'h7FF24193);
    send(iak_ori,  5'd0, 5'd0, 12'h000, 1'b0, 32'h00006013);
    #2 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstq_out_valid", 33'(out_valid), 33'd0);
    chk("rstq_in_ready",  33'(in_ready),  33'd1);
    chk("rstq_out_instr", 33'(out_instr), 33'd0);
`ifdef IMM_ENC_STATS_EN
    chk("rstq_stat_enc", 33'(stat_enc), 33'd0);
`endif
    @(posedge clk); #1 out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstq_no_stale", 33'(out_valid), 33'd0);
    end

    // Flush with two entries queued
    @(posedge clk); #1 out_ready = 1'b0;
    send(iak_andi, 5'd31, 5'd31, 12'h800, 1'b0, 32'h800FFF93);
    send(iak_xori, 5'd3,  5'd4,  12'h7FF, 1'b0, 32'h7FF24193);
`ifdef IMM_ENC_STATS_EN
    @(negedge clk);
    chk("fl_pre_stat_enc", 33'(stat_enc), 33'd2);
    @(posedge clk); #1;
`endif
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("fl_out_valid", 33'(out_valid), 33'd0);
    chk("fl_in_ready",  33'(in_ready),  33'd1);
    chk("fl_hold_instr", 33'(out_instr), 33'h800FFF93);
`ifdef IMM_ENC_STATS_EN
    chk("fl_stat_enc", 33'(stat_enc), 33'd2);
    chk("fl_stat_err", 33'(stat_err), 33'd0);
`endif

    // Flush coinciding with a push: the pushed word is discarded
    @(posedge clk); #1;
    set_req(iak_ori, 5'd9, 5'd9, 12'h123);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fl_push_dropped", 33'(out_valid), 33'd0);
    end
    chk("final_queue", 33'(exp_q.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
